// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, default
// datapath width and the values the output registers take on reset/flush.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_NOR    = 4'd5,
    OP_SLT    = 4'd6,
    OP_SLTU   = 4'd7,
    OP_SLL    = 4'd8,
    OP_SRL    = 4'd9,
    OP_SRA    = 4'd10,
    OP_LUI    = 4'd11,
    OP_PASS_A = 4'd12,
    OP_PASS_B = 4'd13,
    OP_RSV14  = 4'd14,
    OP_RSV15  = 4'd15
  } alu_op_t;

  // A cleared stage looks like a zero result: zero flag set, negative clear.
  localparam logic RST_ZERO     = 1'b1;
  localparam logic RST_NEGATIVE = 1'b0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus zero/negative flags derived from that result.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            negative
);

  alu_op_t   op_e;
  logic [4:0] sh;
  logic      lt_signed;
  logic      lt_unsigned;

  assign op_e        = alu_op_t'(op);
  assign sh          = a[4:0];
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    result = '0;
    case (op_e)
      OP_ADD:    result = a + b;
      OP_SUB:    result = a - b;
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      OP_NOR:    result = ~(a | b);
      OP_SLT:    result = {{(XLEN-1){1'b0}}, lt_signed};
      OP_SLTU:   result = {{(XLEN-1){1'b0}}, lt_unsigned};
      OP_SLL:    result = b << sh;
      OP_SRL:    result = b >> sh;
      OP_SRA:    result = $unsigned($signed(b) >>> sh);
      OP_LUI:    result = {b[15:0], {(XLEN-16){1'b0}}};
      OP_PASS_A: result = a;
      OP_PASS_B: result = b;
      default:   result = '0;
    endcase
  end

  assign zero     = (result == '0);
  assign negative = result[XLEN-1];

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: operand selection, ALU, branch-target adder and the output
// register that feeds the EX/MEM buffer.
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            stall,
  input  logic            flush,
  input  logic            alu_src,
  input  logic            does_shift_amount_need,
  input  logic [3:0]      alu_operation,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic [XLEN-1:0] immediate_data,
  input  logic [4:0]      shamt,
  input  logic [XLEN-1:0] pc_incremented,
  input  logic [XLEN-1:0] branch_offset,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            negative,
  output logic [XLEN-1:0] branch_target
);

  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [XLEN-1:0] core_result;
  logic            core_zero;
  logic            core_negative;
  logic [XLEN-1:0] target_next;

  assign operand_a   = does_shift_amount_need ? {{(XLEN-5){1'b0}}, shamt} : rs_data;
  assign operand_b   = alu_src ? immediate_data : rt_data;
  assign target_next = pc_incremented + branch_offset;

  alu_core #(
    .XLEN(XLEN)
  ) u_alu_core (
    .a        (operand_a),
    .b        (operand_b),
    .op       (alu_operation),
    .result   (core_result),
    .zero     (core_zero),
    .negative (core_negative)
  );

  // Pipeline control: rst_b (async, active-high) clears, then flush clears on
  // the edge, then stall holds; otherwise every edge loads the new result.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      alu_result    <= '0;
      zero          <= RST_ZERO;
      negative      <= RST_NEGATIVE;
      branch_target <= '0;
    end else if (flush) begin
      alu_result    <= '0;
      zero          <= RST_ZERO;
      negative      <= RST_NEGATIVE;
      branch_target <= '0;
    end else if (!stall) begin
      alu_result    <= core_result;
      zero          <= core_zero;
      negative      <= core_negative;
      branch_target <= target_next;
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: directed scenarios plus a randomized
// run scored against a behavioural model of the stage.
module tb_ex_alu_stage;

  localparam int W = 66;  // {branch_target, negative, zero, alu_result}

  logic        clk;
  logic        rst_b;
  logic        stall;
  logic        flush;
  logic        alu_src;
  logic        does_shift_amount_need;
  logic [3:0]  alu_operation;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] immediate_data;
  logic [4:0]  shamt;
  logic [31:0] pc_incremented;
  logic [31:0] branch_offset;
  logic [31:0] alu_result;
  logic        zero;
  logic        negative;
  logic [31:0] branch_target;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  ex_alu_stage dut (
    .clk                    (clk),
    .rst_b                  (rst_b),
    .stall                  (stall),
    .flush                  (flush),
    .alu_src                (alu_src),
    .does_shift_amount_need (does_shift_amount_need),
    .alu_operation          (alu_operation),
    .rs_data                (rs_data),
    .rt_data                (rt_data),
    .immediate_data         (immediate_data),
    .shamt                  (shamt),
    .pc_incremented         (pc_incremented),
    .branch_offset          (branch_offset),
    .alu_result             (alu_result),
    .zero                   (zero),
    .negative               (negative),
    .branch_target          (branch_target)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ua, ub, pow;
    longint sa, sb;
    int n;
    logic [31:0] srl;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    n = int'(a % 32);
    pow = longint'(1) << n;
    srl = 32'(ub / pow);
    case (op)
      0:  return 32'(ua + ub);
      1:  return 32'(ua - ub);
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return (sa < sb) ? 32'd1 : 32'd0;
      7:  return (ua < ub) ? 32'd1 : 32'd0;
      8:  return 32'(ub * pow);
      9:  return srl;
      10: return (sb < 0) ? (srl | ~32'(64'hFFFF_FFFF / pow)) : srl;
      11: return 32'((ub % 65536) * 65536);
      12: return a;
      13: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_stage();
    logic [31:0] a, b, r;
    a = does_shift_amount_need ? 32'(shamt) : rs_data;
    b = alu_src ? immediate_data : rt_data;
    r = ref_alu(int'(alu_operation), a, b);
    return {32'(64'(pc_incremented) + 64'(branch_offset)), r[31], (r == 32'd0), r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_op(input int op, input logic [31:0] rs, input logic [31:0] rt);
    alu_operation = 4'(op);
    rs_data = rs;
    rt_data = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    alu_src                = 1'($urandom_range(1, 0));
    does_shift_amount_need = 1'($urandom_range(1, 0));
    alu_operation          = 4'($urandom_range(15, 0));
    rs_data                = $urandom;
    rt_data                = $urandom;
    immediate_data         = $urandom;
    shamt                  = 5'($urandom_range(31, 0));
    pc_incremented         = $urandom;
    branch_offset          = $urandom;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    stall = 1'b0; flush = 1'b0;
    rst_b = 1'b1;
    randomize_inputs();
    #2;
    checks++;
    if ({branch_target, negative, zero, alu_result} !== {32'd0, 1'b0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL reset_async: got bt=%h n=%b z=%b r=%h want 0/0/1/0",
               branch_target, negative, zero, alu_result);
    end
    tick();
    checks++;
    if ({branch_target, negative, zero, alu_result} !== {32'd0, 1'b0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL reset_held: got bt=%h n=%b z=%b r=%h want 0/0/1/0",
               branch_target, negative, zero, alu_result);
    end
    @(negedge clk);
    rst_b = 1'b0;
    alu_src = 1'b0; does_shift_amount_need = 1'b0;
    set_op(0, 32'd5, 32'd7);
    tick();
    checks++;
    if (alu_result !== 32'd12 || zero !== 1'b0) begin
      errors++;
      $display("FAIL first_load: got r=%h z=%b want 0000000c/0", alu_result, zero);
    end
    // asynchronous reset between edges discards the held value
    #2;
    rst_b = 1'b1;
    #1;
    checks++;
    if (alu_result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_midcycle: got r=%h z=%b want 0/1", alu_result, zero);
    end
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  task automatic test_arith();
    alu_src = 1'b0; does_shift_amount_need = 1'b0;
    set_op(0, 32'hFFFF_FFFF, 32'd1);
    tick();
    checks++;
    if (alu_result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: got r=%h z=%b want 0/1", alu_result, zero);
    end
    set_op(1, 32'd3, 32'd5);
    tick();
    checks++;
    if (alu_result !== 32'hFFFF_FFFE || negative !== 1'b1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_wrap: got r=%h n=%b z=%b want fffffffe/1/0", alu_result, negative, zero);
    end
  endtask

  task automatic test_compare();
    alu_src = 1'b0; does_shift_amount_need = 1'b0;
    set_op(6, 32'hFFFF_FFFF, 32'd1);
    tick();
    checks++;
    if (alu_result !== 32'd1) begin
      errors++;
      $display("FAIL slt: got %h want 00000001", alu_result);
    end
    set_op(7, 32'hFFFF_FFFF, 32'd1);
    tick();
    checks++;
    if (alu_result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL sltu: got r=%h z=%b want 0/1", alu_result, zero);
    end
  endtask

  task automatic test_shifts();
    logic [31:0] want[3];
    want[0] = 32'h0000_0100;
    want[1] = 32'h0800_0001;
    want[2] = 32'hF800_0001;
    alu_src = 1'b0; does_shift_amount_need = 1'b1; shamt = 5'd4;
    rs_data = 32'h0000_0003;  // must be ignored in favour of shamt
    for (int i = 0; i < 3; i++) begin
      alu_operation = 4'(8 + i);
      rt_data = 32'h8000_0010;
      tick();
      checks++;
      if (alu_result !== want[i]) begin
        errors++;
        $display("FAIL shift_op%0d: got %h want %h", 8 + i, alu_result, want[i]);
      end
    end
    shamt = 5'd0;
    for (int i = 0; i < 3; i++) begin
      alu_operation = 4'(8 + i);
      tick();
      checks++;
      if (alu_result !== 32'h8000_0010) begin
        errors++;
        $display("FAIL shift0_op%0d: got %h want 80000010", 8 + i, alu_result);
      end
    end
  endtask

  task automatic test_immediate();
    does_shift_amount_need = 1'b0; alu_src = 1'b1;
    immediate_data = 32'h0000_1234;
    set_op(11, 32'h0, 32'hDEAD_BEEF);
    tick();
    checks++;
    if (alu_result !== 32'h1234_0000) begin
      errors++;
      $display("FAIL lui: got %h want 12340000", alu_result);
    end
    set_op(3, 32'h0000_0001, 32'hFFFF_0000);
    tick();
    checks++;
    if (alu_result !== 32'h0000_1235) begin
      errors++;
      $display("FAIL or_imm: got %h want 00001235", alu_result);
    end
  endtask

  task automatic test_pipeline();
    alu_src = 1'b0; does_shift_amount_need = 1'b0;
    set_op(13, 32'h0, 32'h8765_4321);
    pc_incremented = 32'h0000_0100;
    branch_offset  = 32'hFFFF_FFF0;
    tick();
    checks++;
    if (branch_target !== 32'h0000_00F0 || alu_result !== 32'h8765_4321) begin
      errors++;
      $display("FAIL branch_target: got bt=%h r=%h want 000000f0/87654321", branch_target, alu_result);
    end
    stall = 1'b1;
    set_op(0, 32'd1, 32'd1);
    pc_incremented = 32'h2000;
    tick();
    tick();
    checks++;
    if ({branch_target, negative, zero, alu_result} !== {32'h0000_00F0, 1'b1, 1'b0, 32'h8765_4321}) begin
      errors++;
      $display("FAIL stall_hold: got bt=%h n=%b z=%b r=%h want 000000f0/1/0/87654321",
               branch_target, negative, zero, alu_result);
    end
    flush = 1'b1;
    tick();
    checks++;
    if ({branch_target, negative, zero, alu_result} !== {32'd0, 1'b0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL stall_flush: got bt=%h n=%b z=%b r=%h want 0/0/1/0",
               branch_target, negative, zero, alu_result);
    end
    stall = 1'b0; flush = 1'b0;
    tick();
    checks++;
    if (alu_result !== 32'd2 || branch_target !== 32'h0000_1FF0) begin
      errors++;
      $display("FAIL resume: got r=%h bt=%h want 00000002/00001ff0", alu_result, branch_target);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] held;
    logic [W-1:0] got;
    logic [W-1:0] want;
    held = {branch_target, negative, zero, alu_result};
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      randomize_inputs();
      stall = ($urandom_range(7, 0) == 0);
      flush = ($urandom_range(11, 0) == 0);
      if (flush)      held = {32'd0, 1'b0, 1'b1, 32'd0};
      else if (!stall) held = ref_stage();
      exp_q.push_back(held);
      tick();
      got = {branch_target, negative, zero, alu_result};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_%0d op=%0d: got %h want %h", i, alu_operation, got, want);
      end
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_arith();
    test_compare();
    test_shifts();
    test_immediate();
    test_pipeline();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
Execute-stage arithmetic block for the 5-stage 32-bit MIPS-style pipeline. It does three things:
- selects the ALU operands (rt/immediate for B, rs/shift-amount for A);
- computes the ALU result with zero/negative flags;
- computes the branch target as pc_incremented + branch_offset.
All results are captured in an output register feeding EX/MEM. Sits between the ID/EX buffer and the EX/MEM buffer.

Parameters:
XLEN, 32, datapath width (shift amounts use low 5 bits; design is verified at 32 only).

Ports:
clk  in  1  rising-edge clock
rst_b  in  1  asynchronous reset, active-high (rst_b=1 resets)
stall  in  1  hold all output registers
flush  in  1  clear all output registers on next edge
alu_src  in  1  B select: 0=rt_data, 1=immediate_data
does_shift_amount_need  in  1  A select: 0=rs_data, 1=zero-extended shamt
alu_operation  in  4  operation code (see Behaviour)
rs_data  in  XLEN  register operand rs
rt_data  in  XLEN  register operand rt
immediate_data  in  XLEN  pre-extended immediate
shamt  in  5  instruction shift-amount field
pc_incremented  in  XLEN  PC+4 of the instruction
branch_offset  in  XLEN  sign-extended offset, already shifted left 2
alu_result  out  XLEN  registered ALU result
zero  out  1  registered: alu_result==0
negative  out  1  registered: alu_result[XLEN-1]
branch_target  out  XLEN  registered pc_incremented+branch_offset

Behaviour:
- Operand select: A = does_shift_amount_need ? {27'b0,shamt} : rs_data; B = alu_src ? immediate_data : rt_data.
- Operation codes (R = result):
  - 0 ADD: A+B. Wraps modulo 2^32; no overflow flag or trap.
  - 1 SUB: A-B. Wraps modulo 2^32.
  - 2 AND: A&B.
  - 3 OR: A|B.
  - 4 XOR: A^B.
  - 5 NOR: ~(A|B).
  - 6 SLT: signed A<B → 1, else 0.
  - 7 SLTU: unsigned A<B → 1, else 0.
  - 8 SLL: B<<A[4:0].
  - 9 SRL: B>>A[4:0], logical.
  - 10 SRA: B>>>A[4:0], arithmetic.
  - 11 LUI: {B[15:0],16'b0}.
  - 12 PASS_A: A.
  - 13 PASS_B: B.
  - 14, 15: R=0.
- Flags are derived from R in the same cycle: zero=(R==0), negative=R[31]. Both are registered with R.
- Branch target uses a plain wrap-around 32-bit add. It is independent of alu_operation.
- Latency: 1 cycle. Inputs sampled on a rising edge appear on the outputs after that edge.
- Register update priority per edge: rst_b (async) > flush > stall > load.
  - rst_b=1: alu_result=0, zero=1, negative=0, branch_target=0, immediately and independent of clk. Outputs stay at these values while rst_b is held.
  - flush=1: same values as reset, on the edge.
  - flush=1 together with stall=1: flush wins.
  - stall=1 (no flush): all outputs hold their previous values.
- Reset asserted mid-operation discards any in-flight value. The first load happens on the first rising edge after rst_b deasserts.
- No internal state other than the output registers.

Decomposition:
- Package alu_pkg: 4-bit alu_op_t enum with the codes above; XLEN default; reset constant values.
- Sub-module alu_core (combinational): A, B, op → R, zero, negative.
- Operand muxes and branch adder are inline assigns in ex_alu_stage.

Test Plan:
- Reset: rst_b=1 with random inputs, no clock → alu_result=0, zero=1, negative=0, branch_target=0. Deassert, one edge with ADD rs=5 rt=7 → alu_result=12, zero=0.
- Arithmetic wrap: ADD rs=0xFFFFFFFF rt=1 → alu_result=0, zero=1. SUB rs=3 rt=5 → 0xFFFFFFFE, negative=1.
- Compare: SLT rs=0xFFFFFFFF rt=1 → 1. SLTU with the same operands → 0.
- Shifts (does_shift_amount_need=1, shamt=4, rt=0x80000010):
  - SLL → 0x00000100;
  - SRL → 0x08000001;
  - SRA → 0xF8000001.
  - Also shamt=0 → value unchanged.
- Immediate path: alu_src=1, imm=0x00001234, LUI → 0x12340000. OR with rs=0x00000001 → 0x00001235.
- Pipeline control and branch target:
  - pc_incremented=0x100, branch_offset=0xFFFFFFF0 → branch_target=0xF0.
  - stall=1 then change inputs → outputs unchanged.
  - stall=1 and flush=1 together → outputs cleared to reset values.
